// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth helpers,
// used by both the write-side and read-side pointer blocks.
package fifo_pkg;

    localparam int unsigned PTR_MAXW       = 32;
    localparam int unsigned AWIDTH_DEFAULT = 3;
    localparam int unsigned DEPTH          = 2**AWIDTH_DEFAULT;

    function automatic int unsigned fifo_depth(input int unsigned awidth);
        return 32'd1 << awidth;
    endfunction

    // Callers zero-extend into PTR_MAXW and cast the result back to their width.
    function automatic logic [PTR_MAXW-1:0] bin2gray(input logic [PTR_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
        logic [PTR_MAXW-1:0] b;
        b[PTR_MAXW-1] = g[PTR_MAXW-1];
        for (int unsigned i = PTR_MAXW - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ g[i-1];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB), width W <= 32.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = W'(gray2bin(PTR_MAXW'(gray)));
    end

endmodule

// File: rtl/wptr_wfull.sv
// Write-domain pointer, full / almost-full flags and conservative fill level.
// Define WOVERFLOW_EN to add the sticky woverflow output.
module wptr_wfull
    import fifo_pkg::*;
#(
    parameter int unsigned AWIDTH       = 3,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              winc,
    input  logic [AWIDTH:0]   wq2_rptr,
    output logic [AWIDTH-1:0] waddr,
    output logic [AWIDTH:0]   wptr,
    output logic              wfull,
    output logic              walmost_full,
    output logic [AWIDTH:0]   wlevel
`ifdef WOVERFLOW_EN
    ,
    output logic              woverflow
`endif
);

    localparam int unsigned PW = AWIDTH + 1;

    logic [AWIDTH:0] wbin;
    logic [AWIDTH:0] wbnext;
    logic [AWIDTH:0] wgnext;
    logic [AWIDTH:0] rbin_sync;
    logic [AWIDTH:0] full_cmp;
    logic [AWIDTH:0] level_next;
    logic            wenable;
    logic            wfull_val;
    logic            afull_val;

    gray2bin_conv #(.W(PW)) u_rptr_conv (
        .gray (wq2_rptr),
        .bin  (rbin_sync)
    );

    assign wenable = winc & ~wfull;
    assign wbnext  = wbin + {{AWIDTH{1'b0}}, wenable};
    assign wgnext  = PW'(bin2gray(PTR_MAXW'(wbnext)));
    assign waddr   = wbin[AWIDTH-1:0];

    // Full when the next write pointer equals the read pointer with its top two Gray bits inverted.
    if (AWIDTH == 1) begin : g_cmp_narrow
        assign full_cmp = ~wq2_rptr;
    end else begin : g_cmp_wide
        assign full_cmp = {~wq2_rptr[AWIDTH:AWIDTH-1], wq2_rptr[AWIDTH-2:0]};
    end

    assign wfull_val  = (wgnext == full_cmp);
    assign level_next = wbnext - rbin_sync;
    assign afull_val  = (32'(level_next) >= AFULL_THRESH);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
        end else begin
            wbin         <= wbnext;
            wptr         <= wgnext;
            wfull        <= wfull_val;
            walmost_full <= afull_val;
            wlevel       <= level_next;
        end
    end

`ifdef WOVERFLOW_EN
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            woverflow <= 1'b0;
        end else if (winc && wfull) begin
            woverflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_wptr_wfull.sv
// Self-checking bench for wptr_wfull against a write/read count model.
module tb_wptr_wfull;

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [3:0] wq2_rptr;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
`ifdef WOVERFLOW_EN
    logic       woverflow;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model: total accepted writes, read count seen through wq2_rptr, registered flags.
    int unsigned m_w;
    int unsigned m_r;
    int unsigned m_level;
    bit          m_full;
    bit          m_af;
    bit          m_ovf;

    wptr_wfull #(.AWIDTH(3), .AFULL_THRESH(6)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel)
`ifdef WOVERFLOW_EN
        ,
        .woverflow    (woverflow)
`endif
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [3:0] g4(input int unsigned n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic model_clear();
        m_w = 0; m_r = 0; m_level = 0;
        m_full = 0; m_af = 0; m_ovf = 0;
    endtask

    // Drive at negedge, advance one wclk edge, update the model, land 1ns after the edge.
    task automatic tick(input bit inc, input int unsigned r);
        @(negedge wclk);
        winc     = inc;
        m_r      = r;
        wq2_rptr = g4(r);
        @(posedge wclk);
        if (inc && m_full) m_ovf = 1;
        if (inc && !m_full) m_w++;
        m_level = m_w - m_r;
        m_full  = (m_level == 8);
        m_af    = (m_level >= 6);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b1; winc = 1'b0; wq2_rptr = '0;
        model_clear();
        #2 wrst_n = 1'b0;
        #1;
        checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr: got %0h expected 0", waddr); end
        checks++; if (wptr !== 4'b0000) begin errors++; $display("FAIL reset_wptr: got %0h expected 0", wptr); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL reset_wfull: got %0b expected 0", wfull); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %0b expected 0", walmost_full); end
        checks++; if (wlevel !== 4'd0) begin errors++; $display("FAIL reset_wlevel: got %0d expected 0", wlevel); end
`ifdef WOVERFLOW_EN
        checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL reset_woverflow: got %0b expected 0", woverflow); end
`endif
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int unsigned i = 1; i <= 8; i++) begin
            tick(1'b1, 0);
            checks++; if (walmost_full !== (i >= 6)) begin errors++; $display("FAIL fill_afull_%0d: got %0b expected %0b", i, walmost_full, (i >= 6)); end
            checks++; if (wlevel !== 4'(i)) begin errors++; $display("FAIL fill_level_%0d: got %0d expected %0d", i, wlevel, i); end
            checks++; if (wfull !== (i == 8)) begin errors++; $display("FAIL fill_full_%0d: got %0b expected %0b", i, wfull, (i == 8)); end
        end
        checks++; if (wptr !== 4'b1100) begin errors++; $display("FAIL fill_wptr: got %b expected 1100", wptr); end
        checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL fill_waddr: got %0d expected 0", waddr); end
    endtask

    task automatic test_write_full();
        for (int unsigned i = 0; i < 3; i++) begin
            tick(1'b1, 0);
            checks++; if (wptr !== 4'b1100) begin errors++; $display("FAIL wfull_hold_wptr: got %b expected 1100", wptr); end
            checks++; if (wlevel !== 4'd8) begin errors++; $display("FAIL wfull_hold_level: got %0d expected 8", wlevel); end
            checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL wfull_hold_waddr: got %0d expected 0", waddr); end
        end
`ifdef WOVERFLOW_EN
        checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b expected 1", woverflow); end
        tick(1'b0, 0);
        checks++; if (woverflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky: got %0b expected 1", woverflow); end
`endif
    endtask

    task automatic test_drain();
        tick(1'b0, 2);
        checks++; if (wq2_rptr !== 4'b0011) begin errors++; $display("FAIL drain_stim: got %b expected 0011", wq2_rptr); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL drain_full: got %0b expected 0", wfull); end
        checks++; if (wlevel !== 4'd6) begin errors++; $display("FAIL drain_level: got %0d expected 6", wlevel); end
        tick(1'b1, 2);
        tick(1'b1, 2);
        checks++; if (wfull !== 1'b1) begin errors++; $display("FAIL refill_full: got %0b expected 1", wfull); end
        checks++; if (wptr !== 4'b1111) begin errors++; $display("FAIL refill_wptr: got %b expected 1111", wptr); end
    endtask

    task automatic test_wrap();
        logic [3:0] prev_ptr;
        tick(1'b0, m_w - 1);
        for (int unsigned i = 0; i < 20; i++) begin
            prev_ptr = wptr;
            tick(1'b1, m_w);
            checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL wrap_full_%0d: got %0b expected 0", i, wfull); end
            checks++; if (wlevel !== 4'd1) begin errors++; $display("FAIL wrap_level_%0d: got %0d expected 1", i, wlevel); end
            checks++; if (wptr !== g4(m_w)) begin errors++; $display("FAIL wrap_wptr_%0d: got %b expected %b", i, wptr, g4(m_w)); end
            if (m_w == 16) begin
                checks++; if (prev_ptr !== 4'b1000 || wptr !== 4'b0000) begin errors++; $display("FAIL wrap_edge: got %b->%b expected 1000->0000", prev_ptr, wptr); end
            end
        end
    endtask

    task automatic test_simultaneous();
        tick(1'b0, m_w - 5);
        checks++; if (wlevel !== 4'd5) begin errors++; $display("FAIL simul_pre_level: got %0d expected 5", wlevel); end
        tick(1'b1, m_r + 1);
        checks++; if (wlevel !== 4'd5) begin errors++; $display("FAIL simul_level: got %0d expected 5", wlevel); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL simul_afull: got %0b expected 0", walmost_full); end
        checks++; if (waddr !== 3'(m_w % 8)) begin errors++; $display("FAIL simul_waddr: got %0d expected %0d", waddr, m_w % 8); end
    endtask

    task automatic test_random();
        int unsigned adv;
        int unsigned rd_pct;
        bit          inc;
        for (int unsigned i = 0; i < 400; i++) begin
            rd_pct = (i < 200) ? 30 : 70;
            inc    = ($urandom_range(0, 99) < 60);
            adv    = ($urandom_range(0, 99) < rd_pct) ? $urandom_range(1, 2) : 0;
            if (m_r + adv > m_w) adv = m_w - m_r;
            tick(inc, m_r + adv);
            checks++; if (wptr !== g4(m_w)) begin errors++; $display("FAIL rand_wptr_%0d: got %b expected %b", i, wptr, g4(m_w)); end
            checks++; if (waddr !== 3'(m_w % 8)) begin errors++; $display("FAIL rand_waddr_%0d: got %0d expected %0d", i, waddr, m_w % 8); end
            checks++; if (wlevel !== 4'(m_level)) begin errors++; $display("FAIL rand_level_%0d: got %0d expected %0d", i, wlevel, m_level); end
            checks++; if (wfull !== m_full) begin errors++; $display("FAIL rand_full_%0d: got %0b expected %0b", i, wfull, m_full); end
            checks++; if (walmost_full !== m_af) begin errors++; $display("FAIL rand_afull_%0d: got %0b expected %0b", i, walmost_full, m_af); end
`ifdef WOVERFLOW_EN
            checks++; if (woverflow !== m_ovf) begin errors++; $display("FAIL rand_ovf_%0d: got %0b expected %0b", i, woverflow, m_ovf); end
`endif
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, m_r);
        #3 wrst_n = 1'b0;
        #1;
        checks++; if (waddr !== 3'd0) begin errors++; $display("FAIL areset_waddr: got %0d expected 0", waddr); end
        checks++; if (wptr !== 4'b0000) begin errors++; $display("FAIL areset_wptr: got %b expected 0000", wptr); end
        checks++; if (wfull !== 1'b0) begin errors++; $display("FAIL areset_full: got %0b expected 0", wfull); end
        checks++; if (walmost_full !== 1'b0) begin errors++; $display("FAIL areset_afull: got %0b expected 0", walmost_full); end
        checks++; if (wlevel !== 4'd0) begin errors++; $display("FAIL areset_level: got %0d expected 0", wlevel); end
`ifdef WOVERFLOW_EN
        checks++; if (woverflow !== 1'b0) begin errors++; $display("FAIL areset_ovf: got %0b expected 0", woverflow); end
`endif
        @(negedge wclk);
        winc = 1'b0; wq2_rptr = '0;
        model_clear();
        wrst_n = 1'b1;
        tick(1'b1, 0);
        checks++; if (wptr !== 4'b0001) begin errors++; $display("FAIL post_reset_wptr: got %b expected 0001", wptr); end
        checks++; if (wlevel !== 4'd1) begin errors++; $display("FAIL post_reset_level: got %0d expected 1", wlevel); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_write_full();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wptr_wfull.md
Name: wptr_wfull

Overview:
Write-domain pointer and full-flag generator for the dual-clock async FIFO. It is the write-side counterpart of the read-pointer/empty block.
- Keeps a binary write pointer and drives the RAM write address.
- Exports a Gray-coded write pointer for synchronization into the read domain.
- Compares against the read pointer already synchronized into wclk, producing registered full, almost-full and fill-level indications.

Parameters:
AWIDTH, 3, RAM address width; FIFO depth = 2**AWIDTH; pointers are AWIDTH+1 bits.
AFULL_THRESH, 6, walmost_full asserts when next fill level >= this value; legal range 1..2**AWIDTH.

Ports:
wclk  input  1  write-domain clock, rising edge.
wrst_n  input  1  asynchronous active-low reset of all write-domain state.
winc  input  1  write request; accepted only when wfull==0.
wq2_rptr  input  AWIDTH+1  Gray read pointer, already passed through the external 2-flop synchronizer into wclk.
waddr  output  AWIDTH  RAM write address = low AWIDTH bits of binary write pointer.
wptr  output  AWIDTH+1  registered Gray write pointer, sent to read-domain synchronizer.
wfull  output  1  registered full flag.
walmost_full  output  1  registered almost-full flag.
wlevel  output  AWIDTH+1  registered conservative fill level, 0..2**AWIDTH.

Behaviour:
- Reset (async, wrst_n=0): wbin=0, wptr=0, wfull=0, walmost_full=0, wlevel=0 (woverflow=0 if built); waddr=0 immediately; release is synchronous to the next wclk edge.
- wenable = winc & ~wfull.
- wbnext = wbin + wenable; the addition is modulo 2**(AWIDTH+1), so it wraps naturally with no special case.
- wgnext = (wbnext>>1) ^ wbnext; wptr <= wgnext each edge.
- Full: wfull_val = (wgnext == {~wq2_rptr[AWIDTH:AWIDTH-1], wq2_rptr[AWIDTH-2:0]}); wfull <= wfull_val.
  - wfull rises on the same edge that accepts the 2**AWIDTH-th unread write: zero-cycle lag on the write side.
  - For AWIDTH==1 the comparison uses the top two bits only.
- Level: rbin_sync = Gray-to-binary of wq2_rptr (combinational XOR prefix from MSB); wlevel <= wbnext - rbin_sync, modulo 2**(AWIDTH+1), which is always <= 2**AWIDTH.
- Almost full: walmost_full <= ((wbnext - rbin_sync) >= AFULL_THRESH).
- Conservative by design: wq2_rptr lags the true read pointer by about 2 wclk plus skew. wfull and wlevel may over-report, never under-report. wfull deasserts only when the synchronized pointer advances (one wclk edge after wq2_rptr changes).
- Write while full (winc=1, wfull=1): ignored; wbin, wptr and waddr are unchanged.
- Simultaneous write and read-pointer advance on one edge: both are applied; level = old level + 1 - read delta.
- Reset mid-operation: all outputs clear asynchronously. The read side must be reset at the same time; this is a system rule, not checked here.
- wptr changes at most one bit per edge (Gray property). Monotonic except when held.

Optional Feature:
Macro WOVERFLOW_EN.
- Defined: extra output port woverflow (1 bit), sticky; it sets on any edge where winc & wfull and is cleared only by wrst_n.
- Not defined: the port and its flop do not exist; writes while full are silently dropped.

Decomposition:
- Shared package fifo_pkg holds:
  - function bin2gray(AWIDTH+1) and function gray2bin(AWIDTH+1), also reused by the read side;
  - localparam DEPTH = 2**AWIDTH helper.
- One natural sub-module: gray2bin_conv (parameter W). It is a purely combinational converter instantiated for wq2_rptr; it can be reused by the read block for level reporting.

Test Plan:
(AWIDTH=3, AFULL_THRESH=6 throughout.)
1. Reset: assert wrst_n=0 mid-clock -> waddr=0, wptr=4'b0000, wfull=0, walmost_full=0, wlevel=0 immediately, without waiting for a wclk edge.
2. Fill from empty: wq2_rptr=0, 8 consecutive winc -> walmost_full=1 after the 6th edge; after the 8th edge wfull=1, wptr=4'b1100, wlevel=8, waddr=0.
3. Write while full: hold winc 3 more cycles -> wptr stays 4'b1100 and wlevel stays 8. With WOVERFLOW_EN: woverflow=1 and stays 1 after winc drops.
4. Drain visibility: set wq2_rptr=gray(2)=4'b0011 -> next edge wfull=0, wlevel=6. Then 2 writes -> wfull=1, wptr=gray(10)=4'b1111.
5. Wrap: 20 writes with wq2_rptr tracking wbin-1 -> wbin wraps 15->0 (wptr 4'b1000->4'b0000); wfull never asserts; wlevel stays 1.
6. Simultaneous: level 5, winc=1 on the same edge wq2_rptr advances by 1 -> wlevel stays 5 and walmost_full stays 0.
